// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the regfile_responder block.
package regfile_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 32;
    localparam int ADDR_W    = $clog2(DEPTH_DEF);

    typedef logic [0:0] state_t;
    localparam state_t ST_CLEAR = 1'b0;
    localparam state_t ST_IDLE  = 1'b1;

endpackage

// File: rtl/regfile_array.sv
// Register storage: one synchronous write port, two asynchronous read ports,
// register 0 hardwired to zero.
module regfile_array
    import regfile_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr1_i,
    input  logic [AW-1:0]    raddr2_i,
    output logic [WIDTH-1:0] rdata1_o,
    output logic [WIDTH-1:0] rdata2_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage has no reset; the owner clears it with a write sweep.
    always_ff @(posedge clk_i) begin
        if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0) ? '0 : mem_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : mem_q[raddr2_i];

endmodule

// File: rtl/regfile_responder.sv
// Two-read/one-write register-file responder with post-reset clear sweep and
// response backpressure. Define REGFILE_BYPASS_EN for write-before-read forwarding.
module regfile_responder
    import regfile_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic             RegWrite,
    input  logic [AW-1:0]    WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [AW-1:0]    ReadRegister1,
    input  logic [AW-1:0]    ReadRegister2,
    output logic             RespValid,
    input  logic             RespReady,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2,
    output logic             Busy
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] rd1_q, rd1_d;
    logic [WIDTH-1:0] rd2_q, rd2_d;

    logic             accept;
    logic             arr_we;
    logic [AW-1:0]    arr_waddr;
    logic [WIDTH-1:0] arr_wdata;
    logic [WIDTH-1:0] arr_rd1, arr_rd2;
    logic [WIDTH-1:0] sel_rd1, sel_rd2;

    // Handshake: a request transfers on an edge where ReqValid && ReqReady;
    // a response retires on an edge where RespValid && RespReady. RespValid and
    // ReadData never change while RespValid && !RespReady.
    assign ReqReady = (state_q == ST_IDLE) && (!resp_valid_q || RespReady);
    assign accept   = ReqValid && ReqReady;

    // The clear sweep and requests share the single write port.
    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = WriteRegister;
        arr_wdata = WriteData;
        if (!Reset) begin
            if (state_q == ST_CLEAR) begin
                arr_we    = 1'b1;
                arr_waddr = cnt_q;
                arr_wdata = '0;
            end else begin
                arr_we = accept && RegWrite;
            end
        end
    end

    regfile_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i    (Clk),
        .we_i     (arr_we),
        .waddr_i  (arr_waddr),
        .wdata_i  (arr_wdata),
        .raddr1_i (ReadRegister1),
        .raddr2_i (ReadRegister2),
        .rdata1_o (arr_rd1),
        .rdata2_o (arr_rd2)
    );

    always_comb begin
        sel_rd1 = arr_rd1;
        sel_rd2 = arr_rd2;
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && (WriteRegister != '0)) begin
            if (ReadRegister1 == WriteRegister) sel_rd1 = WriteData;
            if (ReadRegister2 == WriteRegister) sel_rd2 = WriteData;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_IDLE;
            end
        end else begin
            if (accept) begin
                resp_valid_d = 1'b1;
                rd1_d        = sel_rd1;
                rd2_d        = sel_rd2;
            end else if (RespReady) begin
                resp_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_CLEAR;
            cnt_q        <= AW'(1);
            resp_valid_q <= 1'b0;
            rd1_q        <= '0;
            rd2_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
        end
    end

    assign RespValid = resp_valid_q;
    assign ReadData1 = rd1_q;
    assign ReadData2 = rd2_q;
    assign Busy      = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_regfile_responder.sv
// Self-checking bench for regfile_responder: directed steps plus random traffic
// against a behavioural register-file model.
module tb_regfile_responder;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = 5;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          ReqValid;
    logic          ReqReady;
    logic          RegWrite;
    logic [AW-1:0] WriteRegister;
    logic [W-1:0]  WriteData;
    logic [AW-1:0] ReadRegister1;
    logic [AW-1:0] ReadRegister2;
    logic          RespValid;
    logic          RespReady;
    logic [W-1:0]  ReadData1;
    logic [W-1:0]  ReadData2;
    logic          Busy;

    int n_checks = 0;
    int n_err    = 0;

    logic [W-1:0]   model_mem [D];
    logic [2*W-1:0] exp_q [$];
    logic [2*W-1:0] last_resp;

    regfile_responder dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .ReqValid      (ReqValid),
        .ReqReady      (ReqReady),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .RespValid     (RespValid),
        .RespReady     (RespReady),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .Busy          (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) model_mem[i] = '0;
        exp_q.delete();
        last_resp = '0;
    endtask

    function automatic logic [W-1:0] model_read(input logic [AW-1:0] r, input logic we,
                                                input logic [AW-1:0] wa, input logic [W-1:0] wd);
        if (r == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && (wa != 0) && (wa == r)) return wd;
`endif
        return model_mem[r];
    endfunction

    // One clock cycle of traffic, driven and checked against the model.
    task automatic cycle(input logic rv, input logic we, input logic [AW-1:0] wa,
                         input logic [W-1:0] wd, input logic [AW-1:0] r1,
                         input logic [AW-1:0] r2, input logic rr);
        logic           exp_ready;
        logic           acc;
        logic [W-1:0]   e1, e2;
        ReqValid      = rv;
        RegWrite      = we;
        WriteRegister = wa;
        WriteData     = wd;
        ReadRegister1 = r1;
        ReadRegister2 = r2;
        RespReady     = rr;
        #1;
        exp_ready = (exp_q.size() == 0) || rr;
        check("req_ready", 64'(ReqReady), 64'(exp_ready));
        check("busy_idle", 64'(Busy), 64'(0));
        acc = rv && exp_ready;
        if ((exp_q.size() > 0) && rr) last_resp = exp_q.pop_front();
        if (acc) begin
            e1 = model_read(r1, we, wa, wd);
            e2 = model_read(r2, we, wa, wd);
            if (we && (wa != 0)) model_mem[wa] = wd;
            exp_q.push_back({e1, e2});
        end
        @(posedge Clk);
        #1;
        if (exp_q.size() > 0) begin
            check("resp_valid", 64'(RespValid), 64'(1));
            check("resp_data", {ReadData1, ReadData2}, exp_q[0]);
        end else begin
            check("resp_idle", 64'(RespValid), 64'(0));
            check("resp_hold", {ReadData1, ReadData2}, last_resp);
        end
    endtask

    task automatic sweep_wait(input string tag);
        for (int i = 0; i < D - 1; i++) begin
            check({tag, "_busy"}, 64'(Busy), 64'(1));
            check({tag, "_ready"}, 64'(ReqReady), 64'(0));
            tick();
        end
        check({tag, "_done_busy"}, 64'(Busy), 64'(0));
        check({tag, "_done_ready"}, 64'(ReqReady), 64'(1));
    endtask

    initial begin
        Reset         = 1'b1;
        ReqValid      = 1'b0;
        RegWrite      = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        RespReady     = 1'b1;
        model_reset();

        tick();
        tick();
        check("rst_resp_valid", 64'(RespValid), 64'(0));
        check("rst_data", {ReadData1, ReadData2}, 64'(0));
        check("rst_busy", 64'(Busy), 64'(1));
        check("rst_ready", 64'(ReqReady), 64'(0));

        Reset = 1'b0;
        sweep_wait("sweep");

        for (int i = 1; i < D; i++) begin
            cycle(1'b1, 1'b0, '0, '0, AW'(i), AW'(D - i), 1'b1);
        end

        cycle(1'b1, 1'b1, 5'd2, 32'd42, 5'd2, 5'd2, 1'b1);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd2, 5'd2, 1'b1);
        cycle(1'b1, 1'b1, 5'd5, 32'd5, 5'd1, 5'd4, 1'b1);
        cycle(1'b1, 1'b0, 5'd5, 32'd21, 5'd5, 5'd5, 1'b1);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd2, 5'd5, 1'b1);
        cycle(1'b1, 1'b1, 5'd0, 32'd15, 5'd1, 5'd1, 1'b1);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
        cycle(1'b1, 1'b1, 5'd11, 32'd15, 5'd1, 5'd1, 1'b1);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd11, 1'b1);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);

        // Backpressure: held response, blocked write to r3 must not commit.
        cycle(1'b1, 1'b1, 5'd3, 32'd7, 5'd3, 5'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 5'd3, 32'd99, 5'd3, 5'd3, 1'b0);
        end
        cycle(1'b1, 1'b0, 5'd3, 32'd0, 5'd3, 5'd3, 1'b1);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 1'b1);

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 7)), $urandom,
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0);
        end

        // Reset while a response is pending.
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
        cycle(1'b1, 1'b1, 5'd11, 32'h1234, 5'd11, 5'd2, 1'b0);
        ReqValid = 1'b0;
        Reset    = 1'b1;
        tick();
        check("midrst_resp_valid", 64'(RespValid), 64'(0));
        check("midrst_data", {ReadData1, ReadData2}, 64'(0));
        check("midrst_busy", 64'(Busy), 64'(1));
        Reset = 1'b0;
        model_reset();
        sweep_wait("resweep");
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd11, 5'd2, 1'b1);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd3, 5'd5, 1'b1);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
